load_buffer_mp: RTL

LOAD_BUFFER_MP -- requirements
Module: load_buffer_mp

---
 rtl/load_buffer_mp.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_buffer_mp.sv
// Multi-port-fill load buffer: holds loads waiting on cache fills, merges fill bytes and presents results to the CDB.
// Optional macro LOAD_BUFFER_OLDEST_FIRST_EN restricts cdb_req to the entry that has been READY longest.
module load_buffer_mp #(
   parameter int DEPTH      = 4,
   parameter int FILL_PORTS = 2,
   parameter int MSHR_IDX_W = 3,
   parameter int BM_W       = 4,
   parameter int DEST_W     = 6,
   localparam int PKT_W     = 32 + 3 + DEST_W + BM_W + MSHR_IDX_W + 4 + 32,
   localparam int CDB_W     = 1 + DEST_W + 32,
   localparam int OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             alloc_valid,
   input  logic [PKT_W-1:0]                 alloc_pkt,
   output logic                             alloc_ready,
   input  logic [FILL_PORTS-1:0]            fill_valid,
   input  logic [FILL_PORTS*MSHR_IDX_W-1:0] fill_mshr_idx,
   input  logic [FILL_PORTS*64-1:0]         fill_data,
   output logic [DEPTH-1:0]                 cdb_req,
   input  logic [DEPTH-1:0]                 cdb_gnt,
   output logic [DEPTH*CDB_W-1:0]           load_result,
   input  logic [BM_W-1:0]                  b_mm_resolve,
   input  logic                             b_mm_mispred,
   output logic [OCC_W-1:0]                 occupancy
);

   // Packet layout, LSB first: result, byte_mask, mshr_idx, bm, dest, func, addr
   localparam int P_RES  = 0;
   localparam int P_MASK = 32;
   localparam int P_MSHR = P_MASK + 4;
   localparam int P_BM   = P_MSHR + MSHR_IDX_W;
   localparam int P_DEST = P_BM + BM_W;
   localparam int P_FUNC = P_DEST + DEST_W;
   localparam int P_ADDR = P_FUNC + 3;
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_e;

   state_e                state_q [DEPTH];
   state_e                state_d [DEPTH];
   logic [31:0]           word_q  [DEPTH];
   logic [31:0]           word_d  [DEPTH];
   logic [3:0]            mask_q  [DEPTH];
   logic [3:0]            mask_d  [DEPTH];
   logic [MSHR_IDX_W-1:0] mshr_q  [DEPTH];
   logic [MSHR_IDX_W-1:0] mshr_d  [DEPTH];
   logic [BM_W-1:0]       bm_q    [DEPTH];
   logic [BM_W-1:0]       bm_d    [DEPTH];
   logic [DEST_W-1:0]     dest_q  [DEPTH];
   logic [DEST_W-1:0]     dest_d  [DEPTH];
   logic [2:0]            func_q  [DEPTH];
   logic [2:0]            func_d  [DEPTH];
   logic [1:0]            off_q   [DEPTH];
   logic [1:0]            off_d   [DEPTH];
   logic                  widx_q  [DEPTH];
   logic                  widx_d  [DEPTH];

   logic [31:0]           pkt_res;
   logic [3:0]            pkt_mask;
   logic [MSHR_IDX_W-1:0] pkt_mshr;
   logic [BM_W-1:0]       pkt_bm;
   logic [DEST_W-1:0]     pkt_dest;
   logic [2:0]            pkt_func;
   logic [1:0]            pkt_off;
   logic                  pkt_widx;
   logic                  unused_addr_hi;

   assign pkt_res        = alloc_pkt[P_RES  +: 32];
   assign pkt_mask       = alloc_pkt[P_MASK +: 4];
   assign pkt_mshr       = alloc_pkt[P_MSHR +: MSHR_IDX_W];
   assign pkt_bm         = alloc_pkt[P_BM   +: BM_W];
   assign pkt_dest       = alloc_pkt[P_DEST +: DEST_W];
   assign pkt_func       = alloc_pkt[P_FUNC +: 3];
   assign pkt_off        = alloc_pkt[P_ADDR +: 2];
   assign pkt_widx       = alloc_pkt[P_ADDR + 2];
   // Only the word select and byte offset of the address matter here
   assign unused_addr_hi = ^alloc_pkt[P_ADDR + 3 +: 29];

   logic [DEPTH-1:0] ready_vec;
   logic [IDX_W-1:0] alloc_idx;
   logic             any_free;
   logic             alloc_fire;
   logic             alloc_kill;
   logic [OCC_W-1:0] occ_cnt;

   // Returns {hit, selected word}; the lowest-indexed matching port wins
   function automatic logic [32:0] fill_lookup(
      input logic [MSHR_IDX_W-1:0]            idx,
      input logic                             widx,
      input logic [FILL_PORTS-1:0]            fv,
      input logic [FILL_PORTS*MSHR_IDX_W-1:0] fm,
      input logic [FILL_PORTS*64-1:0]         fd
   );
      logic [32:0] r;
      r = '0;
      for (int p = FILL_PORTS - 1; p >= 0; p--) begin
         if (fv[p] && (fm[p*MSHR_IDX_W +: MSHR_IDX_W] == idx)) begin
            r = {1'b1, widx ? fd[p*64 + 32 +: 32] : fd[p*64 +: 32]};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_w,
      input logic [3:0]  m,
      input logic [31:0] new_w
   );
      logic [31:0] r;
      for (int j = 0; j < 4; j++) begin
         r[8*j +: 8] = m[j] ? new_w[8*j +: 8] : old_w[8*j +: 8];
      end
      return r;
   endfunction

   always_comb begin
      any_free  = 1'b0;
      alloc_idx = '0;
      occ_cnt   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready_vec[i] = (state_q[i] == ST_READY);
         if (state_q[i] == ST_FREE) begin
            any_free  = 1'b1;
            alloc_idx = IDX_W'(i);
         end else begin
            occ_cnt = occ_cnt + OCC_W'(1);
         end
      end
   end

   assign alloc_ready = any_free;
   assign occupancy   = occ_cnt;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_kill  = b_mm_mispred && (|(pkt_bm & b_mm_resolve));

   always_comb begin
      logic [32:0] fl;
      logic [32:0] fla;
      fla = fill_lookup(pkt_mshr, pkt_widx, fill_valid, fill_mshr_idx, fill_data);
      for (int i = 0; i < DEPTH; i++) begin
         state_d[i] = state_q[i];
         word_d[i]  = word_q[i];
         mask_d[i]  = mask_q[i];
         mshr_d[i]  = mshr_q[i];
         bm_d[i]    = bm_q[i] & ~b_mm_resolve;
         dest_d[i]  = dest_q[i];
         func_d[i]  = func_q[i];
         off_d[i]   = off_q[i];
         widx_d[i]  = widx_q[i];

         fl = fill_lookup(mshr_q[i], widx_q[i], fill_valid, fill_mshr_idx, fill_data);
         if ((state_q[i] == ST_WAIT) && fl[32]) begin
            word_d[i]  = merge_bytes(word_q[i], mask_q[i], fl[31:0]);
            mask_d[i]  = 4'd0;
            state_d[i] = ST_READY;
         end

         if ((state_q[i] == ST_READY) && cdb_req[i] && cdb_gnt[i]) begin
            state_d[i] = ST_FREE;
         end

         if ((state_q[i] == ST_FREE) && alloc_fire && !alloc_kill && (alloc_idx == IDX_W'(i))) begin
            mshr_d[i] = pkt_mshr;
            bm_d[i]   = pkt_bm & ~b_mm_resolve;
            dest_d[i] = pkt_dest;
            func_d[i] = pkt_func;
            off_d[i]  = pkt_off;
            widx_d[i] = pkt_widx;
            if ((pkt_mask != 4'd0) && fla[32]) begin
               word_d[i]  = merge_bytes(pkt_res, pkt_mask, fla[31:0]);
               mask_d[i]  = 4'd0;
               state_d[i] = ST_READY;
            end else begin
               word_d[i]  = pkt_res;
               mask_d[i]  = pkt_mask;
               state_d[i] = (pkt_mask == 4'd0) ? ST_READY : ST_WAIT;
            end
         end

         // A mispredict squash beats any fill or grant on the same entry
         if (b_mm_mispred && (state_q[i] != ST_FREE) && (|(bm_q[i] & b_mm_resolve))) begin
            state_d[i] = ST_FREE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_FREE;
            word_q[i]  <= '0;
            mask_q[i]  <= '0;
            mshr_q[i]  <= '0;
            bm_q[i]    <= '0;
            dest_q[i]  <= '0;
            func_q[i]  <= '0;
            off_q[i]   <= '0;
            widx_q[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= state_d[i];
            word_q[i]  <= word_d[i];
            mask_q[i]  <= mask_d[i];
            mshr_q[i]  <= mshr_d[i];
            bm_q[i]    <= bm_d[i];
            dest_q[i]  <= dest_d[i];
            func_q[i]  <= func_d[i];
            off_q[i]   <= off_d[i];
            widx_q[i]  <= widx_d[i];
         end
      end
   end

`ifdef LOAD_BUFFER_OLDEST_FIRST_EN
   // older_q[i][j] = 1: entry j became READY before entry i
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];
   logic [DEPTH-1:0] newly_ready;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         newly_ready[i] = (state_d[i] == ST_READY) && (state_q[i] != ST_READY);
      end
      for (int i = 0; i < DEPTH; i++) begin
         older_d[i] = older_q[i] & ~newly_ready;
         // Simultaneous arrivals are ordered by entry index
         if (newly_ready[i]) begin
            older_d[i] = ready_vec | (newly_ready & ((DEPTH'(1) << i) - DEPTH'(1)));
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         cdb_req[i] = ready_vec[i] && !(|(older_q[i] & ready_vec));
      end
   end
`else
   assign cdb_req = ready_vec;
`endif

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_res
      logic [31:0] shifted;
      logic [31:0] ext;
      always_comb begin
         shifted = word_q[gi] >> {off_q[gi], 3'b000};
         case (func_q[gi][1:0])
            2'd0:    ext = func_q[gi][2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ext = func_q[gi][2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
         endcase
      end
      assign load_result[gi*CDB_W +: CDB_W] = ready_vec[gi] ? {1'b1, dest_q[gi], ext} : '0;
   end

endmodule
